// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: receives 11-bit PS/2 keyboard frames and writes each validated
// scan-code byte into the input FIFO.
// Optional feature macro: PS2_RX_PARITY_CHECK_EN (when defined, a parity
// mismatch is a frame error; when undefined, the parity bit is ignored).
//
// Write-side handshake: wr is a one-cycle strobe with no ready/acknowledge.
// The FIFO full flag is sampled on the cycle the stop-bit fall is processed
// and only chooses between wr (full=0) and drop (full=1); the keyboard is
// never stalled and nothing is retried.
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       full,
    output logic       wr,
    output logic [7:0] w_data,
    output logic       frame_err,
    output logic       drop,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // The timer counts up to TIMEOUT_CYCLES-2 after the fall that cleared it;
    // the register write on the following edge lands frame_err exactly
    // TIMEOUT_CYCLES cycles after that fall pulse.
    localparam int TW          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_INT = (TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0;
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LAST_INT);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] filt;
    logic [FILTER_LEN-1:0] filt_next;
    logic                  clk_f;
    logic                  clk_f_next;
    logic                  fall;
    logic                  data_s;

    state_t                state;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic [TW-1:0]         timer;
    logic                  frame_ok;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic                  par_bit;
`endif

    assign filt_next = {filt[FILTER_LEN-2:0], clk_sync[1]};
    assign data_s    = data_sync[1];
    assign state_dbg = state;

    // Filtered clock level: change only when the whole window agrees.
    always_comb begin
        clk_f_next = clk_f;
        if (&filt_next) begin
            clk_f_next = 1'b1;
        end else if (~|filt_next) begin
            clk_f_next = 1'b0;
        end
    end

    // Frame validity at the stop bit: stop must be 1, plus odd parity if enabled.
    always_comb begin
`ifdef PS2_RX_PARITY_CHECK_EN
        frame_ok = data_s & (^{shreg, par_bit});
`else
        frame_ok = data_s;
`endif
    end

    // Pin synchronisers, glitch filter and registered falling-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= '1;
            clk_f     <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt      <= filt_next;
            clk_f     <= clk_f_next;
            fall      <= clk_f & ~clk_f_next;
        end
    end

    // Frame FSM with timeout and registered one-cycle result pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            timer     <= '0;
            wr        <= 1'b0;
            drop      <= 1'b0;
            frame_err <= 1'b0;
            w_data    <= 8'h00;
`ifdef PS2_RX_PARITY_CHECK_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            wr        <= 1'b0;
            drop      <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE) begin
                timer <= '0;
                // A fall with data=1 is not a start bit and is silently ignored.
                if (fall && !data_s) begin
                    state   <= DATA;
                    bit_cnt <= 3'd0;
                end
            end else if (fall) begin
                timer <= '0;
                case (state)
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                        par_bit <= data_s;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            frame_err <= 1'b1;
                        end else if (full) begin
                            drop <= 1'b1;
                        end else begin
                            wr     <= 1'b1;
                            w_data <= shreg;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (timer == TO_LAST) begin
                state     <= IDLE;
                timer     <= '0;
                frame_err <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule
